fir_mac_sequencer: RTL and testbench
====================================

# fir_mac_sequencer

Time-multiplexed FIR controller: sequences one shared multiply-accumulate unit across FIR_order+1 taps for each accepted input sample. Holds the programmable coefficient bank and the sample delay line. Delivers the same result as the fully pipelined direct-form FIR MAC: one multiplier instead of FIR_order+1, at one output per FIR_order+2 clocks. Sits between the sample source (valid/ready) and downstream output logic.

## Interface
- FIR_order, 4, filter order; taps = FIR_order+1
- Sample_size, 6, unsigned sample width
- weight_size, 5, unsigned coefficient width
- word_size_out, 2*Sample_size+2, accumulator/output width
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- sample_in  in  Sample_size  input sample
- sample_valid  in  1  sample_in is valid
- sample_ready  out  1  block can accept a sample this cycle
- coef_wr  in  1  coefficient write strobe
- coef_addr  in  3  tap index 0..FIR_order
- coef_data  in  weight_size  coefficient value
- fir_out  out  word_size_out  filter result, held until next result
- fir_valid  out  1  one-cycle pulse, fir_out updated
- busy  out  1  MAC sequence in progress

## Operation
- Reset: delay line taps[0..FIR_order] = 0, coef[0..FIR_order] = 0, acc = 0, k = 0, fir_out = 0, fir_valid = 0, state = IDLE. While reset is high: sample_ready = 0, busy = 0, coef writes ignored.
- States: IDLE, MAC.
- IDLE: sample_ready = 1, busy = 0.
  - Accept on edge with sample_valid & sample_ready: taps shift (taps[i] <= taps[i-1], taps[0] <= sample_in), acc <= 0, k <= 0, state <= MAC.
- MAC: sample_ready = 0, busy = 1. Each edge: acc <= acc + taps[k]*coef[k], k <= k+1.
  - On the edge where k == FIR_order: fir_out <= acc + taps[k]*coef[k], fir_valid <= 1, state <= IDLE.
- Result = sum over k of coef[k]*x[n-k]. This is bit-exact to the direct-form FIR for the same coefficients.
- Coefficient writes:
  - Accepted only in IDLE (not in reset). Write coef[coef_addr] <= coef_data.
  - coef_addr > FIR_order: ignored.
  - coef_wr in MAC: ignored, no effect on current or later results.
  - Write on the same edge as a sample accept: the new value is used for that sample's computation.
- Arithmetic: all unsigned. Product width Sample_size+weight_size = 11. acc and fir_out are word_size_out = 14 bits. Worst case 63*31*5 = 9765 fits, so there is no overflow or saturation logic.
- sample_valid while not ready: the sample is not consumed. The source holds it; no internal buffering.

## Timing
- Accept at edge E0. Terms k = 0..FIR_order accumulate at edges E1..E(FIR_order+1).
- fir_valid is high for exactly the cycle after E(FIR_order+1), i.e. the cycle after E5 for defaults. fir_out is valid from that cycle on.
- sample_ready returns high in the same cycle fir_valid is high. A new sample may be accepted at the next edge.
- Throughput: one sample per FIR_order+2 = 6 clocks with sample_valid held high.
- fir_valid is 0 in every other cycle. fir_out holds its value between results.
- Reset asserted mid-MAC:
  - Aborts at that edge: no fir_valid, fir_out = 0, delay line and coefficients cleared.
  - The first cycle after reset deasserts is IDLE with sample_ready = 1.

## Test plan
- Impulse response: reset 4 cycles; program coef = 1,2,3,4,5; feed samples 1,0,0,0,0,0, each on ready -> fir_out sequence 1,2,3,4,5,0. Each fir_valid falls 6 clocks after its accept edge.
- Step: coef all 1; feed 10 five times then 0 -> fir_out 10,20,30,40,50,40. Repeat with coef = 1,2,3,4,5 -> 10,30,60,100,150,140.
- Max value: coef all 31; feed 63 five times -> final fir_out = 9765 with no wrap. Then feed five 0s -> 0.
- Coefficient write protection:
  - coef_wr to addr 0 with data 7 issued during MAC -> ignored; result matches old coef.
  - Write to addr 6 -> ignored.
  - Write in IDLE with a simultaneous accept -> new value used.
- Handshake: hold sample_valid high with changing samples -> sample_ready pulses every 6 cycles. Only samples present on ready cycles are consumed; outputs match a reference model.
- Reset mid-MAC: assert reset 2 cycles after an accept -> no fir_valid, fir_out = 0, coef = 0. After release, sample_ready = 1 and an impulse input gives all-zero outputs until coefficients are reloaded.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared multiply-accumulate unit walks all FIR_order+1 taps
// per accepted sample, giving the direct-form result once every FIR_order+2 clocks.
module fir_mac_sequencer #(
    parameter int FIR_order     = 4,
    parameter int Sample_size   = 6,
    parameter int weight_size   = 5,
    parameter int word_size_out = 2*Sample_size+2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [Sample_size-1:0]   sample_in,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    input  logic                     coef_wr,
    input  logic [2:0]               coef_addr,
    input  logic [weight_size-1:0]   coef_data,
    output logic [word_size_out-1:0] fir_out,
    output logic                     fir_valid,
    output logic                     busy
);
    localparam int Taps = FIR_order + 1;
    localparam int KW   = (Taps > 1) ? $clog2(Taps) : 1;
    localparam int PW   = Sample_size + weight_size;

    typedef enum logic {IDLE, MAC} state_t;

    state_t                   state_q, state_d;
    logic [Sample_size-1:0]   taps_q [Taps];
    logic [weight_size-1:0]   coef_q [Taps];
    logic [word_size_out-1:0] acc_q;
    logic [word_size_out-1:0] fir_out_q;
    logic [KW-1:0]            k_q;
    logic                     fir_valid_q;

    logic                     accept;
    logic                     coef_we;
    logic                     last_tap;
    logic [PW-1:0]            product;
    logic [word_size_out-1:0] acc_sum;

    assign accept   = sample_valid && sample_ready;
    assign last_tap = (state_q == MAC) && (k_q == KW'(FIR_order));
    assign coef_we  = coef_wr && (state_q == IDLE) && (int'(coef_addr) <= FIR_order);
    assign product  = taps_q[k_q] * coef_q[k_q];
    assign acc_sum  = acc_q + word_size_out'(product);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = MAC;
            MAC:     if (last_tap) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is held, not just after it is sampled.
    always_comb begin
        sample_ready = 1'b0;
        busy         = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE:    sample_ready = 1'b1;
                MAC:     busy         = 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the delay line and coefficient bank are small register arrays that must clear on reset, so they are reset explicitly.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < Taps; i++) begin
                taps_q[i] <= '0;
                coef_q[i] <= '0;
            end
            acc_q       <= '0;
            k_q         <= '0;
            fir_out_q   <= '0;
            fir_valid_q <= 1'b0;
        end else begin
            fir_valid_q <= 1'b0;
            // A write landing on the accept edge is visible from the first MAC cycle onward.
            if (coef_we) coef_q[coef_addr] <= coef_data;
            if (accept) begin
                for (int i = Taps - 1; i > 0; i--) taps_q[i] <= taps_q[i-1];
                taps_q[0] <= sample_in;
                acc_q     <= '0;
                k_q       <= '0;
            end else if (state_q == MAC) begin
                acc_q <= acc_sum;
                k_q   <= k_q + 1'b1;
                if (last_tap) begin
                    fir_out_q   <= acc_sum;
                    fir_valid_q <= 1'b1;
                end
            end
        end
    end

    assign fir_out   = fir_out_q;
    assign fir_valid = fir_valid_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer: driver pushes expected results and result cycles,
// an independent monitor pops and compares on every fir_valid pulse.
module tb_fir_mac_sequencer;
    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        coef_wr;
    logic [2:0]  coef_addr;
    logic [4:0]  coef_data;
    logic [13:0] fir_out;
    logic        fir_valid;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_q[$];
    int cyc_q[$];
    int m_taps[5];
    int m_coef[5];

    fir_mac_sequencer dut (
        .clock(clock), .reset(reset),
        .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .fir_out(fir_out), .fir_valid(fir_valid), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model of the direct-form FIR, used for the free-running handshake phase.
    function automatic int model_accept(input int s);
        int sum = 0;
        for (int i = 4; i > 0; i--) m_taps[i] = m_taps[i-1];
        m_taps[0] = s;
        for (int i = 0; i < 5; i++) sum += m_taps[i] * m_coef[i];
        return sum;
    endfunction

    always @(negedge clock) begin
        if (fir_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_fir_valid", 32'd1, 32'd0);
            end else begin
                check("fir_out", fir_out, exp_q.pop_front());
                check("fir_valid_cycle", cyc, cyc_q.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        @(negedge clock);
        while (sample_ready !== 1'b1 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (sample_ready !== 1'b1) check("ready_timeout", sample_ready, 32'd1);
    endtask

    task automatic write_coef(input int addr, input int data);
        wait_ready();
        coef_wr   = 1'b1;
        coef_addr = 3'(addr);
        coef_data = 5'(data);
        if (addr <= 4) m_coef[addr] = data;
        @(posedge clock);
        #1 coef_wr = 1'b0;
    endtask

    task automatic load_coefs(input int c0, input int c1, input int c2, input int c3, input int c4);
        write_coef(0, c0); write_coef(1, c1); write_coef(2, c2);
        write_coef(3, c3); write_coef(4, c4);
    endtask

    // Presents a sample (optionally with a same-edge coefficient write) and queues its hand-computed result.
    task automatic send(input int s, input bit wr, input int addr, input int data, input int exp);
        int m;
        wait_ready();
        sample_in    = 6'(s);
        sample_valid = 1'b1;
        coef_wr      = wr;
        coef_addr    = 3'(addr);
        coef_data    = 5'(data);
        if (wr && addr <= 4) m_coef[addr] = data;
        m = model_accept(s);
        exp_q.push_back(exp);
        cyc_q.push_back(cyc + 6);
        @(posedge clock);
        #1 sample_valid = 1'b0;
        coef_wr = 1'b0;
    endtask

    task automatic feed(input int s, input int exp);
        send(s, 1'b0, 0, 0, exp);
    endtask

    initial begin
        int prev_rdy;
        int guard;
        reset = 1'b1; sample_in = '0; sample_valid = 1'b0;
        coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
        for (int i = 0; i < 5; i++) begin m_taps[i] = 0; m_coef[i] = 0; end

        repeat (4) @(negedge clock);
        check("reset_ready", sample_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_fir_out", fir_out, 0);
        check("reset_fir_valid", fir_valid, 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_ready", sample_ready, 1);
        check("idle_busy", busy, 0);

        // Impulse response
        load_coefs(1, 2, 3, 4, 5);
        feed(1, 1); feed(0, 2); feed(0, 3); feed(0, 4); feed(0, 5); feed(0, 0);

        // Step with unit coefficients, then drain
        load_coefs(1, 1, 1, 1, 1);
        feed(10, 10); feed(10, 20); feed(10, 30); feed(10, 40); feed(10, 50); feed(0, 40);
        feed(0, 30); feed(0, 20); feed(0, 10); feed(0, 0);

        // Step with ramp coefficients
        load_coefs(1, 2, 3, 4, 5);
        feed(10, 10); feed(10, 30); feed(10, 60); feed(10, 100); feed(10, 150); feed(0, 140);

        // Maximum values: no wrap at 9765
        load_coefs(31, 31, 31, 31, 31);
        feed(63, 2883); feed(63, 4526); feed(63, 6169); feed(63, 7812); feed(63, 9765);
        feed(0, 7812); feed(0, 5859); feed(0, 3906); feed(0, 1953); feed(0, 0);

        // Coefficient write protection
        load_coefs(1, 2, 3, 4, 5);
        feed(2, 2);
        coef_wr = 1'b1; coef_addr = 3'd0; coef_data = 5'd7;
        @(posedge clock);
        #1 coef_wr = 1'b0;
        feed(3, 7);
        write_coef(6, 31);
        feed(0, 12);
        send(1, 1'b1, 0, 6, 23);

        // Held sample_valid with a changing sample: only ready-cycle samples are consumed
        prev_rdy = -1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            sample_in    = 6'((i * 7 + 5) % 64);
            sample_valid = 1'b1;
            if (sample_ready === 1'b1) begin
                if (prev_rdy >= 0) check("ready_period", cyc - prev_rdy, 6);
                prev_rdy = cyc;
                exp_q.push_back(model_accept(int'(sample_in)));
                cyc_q.push_back(cyc + 6);
            end
        end
        @(posedge clock);
        #1 sample_valid = 1'b0;

        // Reset two cycles into a MAC sequence
        feed(5, 0);
        @(negedge clock);
        check("mac_busy", busy, 1);
        check("mac_ready", sample_ready, 0);
        @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        cyc_q.delete();
        @(negedge clock);
        check("abort_fir_out", fir_out, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", sample_ready, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin m_taps[i] = 0; m_coef[i] = 0; end
        @(negedge clock);
        check("post_reset_ready", sample_ready, 1);
        check("post_reset_fir_out", fir_out, 0);
        feed(1, 0); feed(0, 0); feed(0, 0); feed(0, 0); feed(0, 0);
        load_coefs(1, 2, 3, 4, 5);
        feed(1, 1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (10) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
